spi_reg_peripheral: RTL and testbench
=====================================

// Module: spi_reg_peripheral
// PURPOSE
//   Parametrised SPI (mode 0) peripheral exposing NUM_REGS x DATA_W control registers to the PWM/IO logic.
//   Oversamples sclk/COPI/nCS in the clk domain and decodes fixed-length frames: {rw, addr, data}, MSB first.
//   Commits validated writes atomically on nCS deassert; optional CIPO readback of any register.
// PARAMETERS
//   NUM_REGS  5  number of registers; valid addr 0..NUM_REGS-1
//   DATA_W    8  register width
//   ADDR_W    7  address field width; FRAME_W = 1 + ADDR_W + DATA_W (16 at defaults)
// PORTS
//   clk        in   1                  system clock; must be >= 4x sclk frequency
//   rst_n      in   1                  asynchronous active-low reset
//   sclk       in   1                  SPI clock (async)
//   COPI       in   1                  SPI data in (async)
//   nCS        in   1                  SPI chip select, active low (async)
//   CIPO       out  1                  SPI data out; 0 when unused
//   regs_o     out  NUM_REGS*DATA_W    flattened registers, reg i at [i*DATA_W +: DATA_W]
//   wr_pulse   out  1                  one-clk strobe when a write commits
//   wr_addr    out  ADDR_W             address of the last committed write
//   frame_err  out  1                  one-clk strobe when a frame is rejected
// BEHAVIOUR
//   - Reset: all regs_o, wr_addr, CIPO, wr_pulse, frame_err, bit counter, shift reg = 0; FSM = IDLE.
//   - Inputs pass 2-flop synchronisers; edges detected from synchronised samples (rise/fall = 1-clk pulses).
//   - FSM IDLE -> SHIFT on nCS fall: bit_cnt=0, shift reg cleared.
//   - SHIFT: on sclk rise shift {sr, COPI}, bit_cnt++ (saturates at FRAME_W+1). sclk edges ignored in IDLE.
//   - SHIFT -> COMMIT on nCS rise; an sclk rise in the same clk as nCS rise is discarded.
//   - COMMIT (one clk, then IDLE): write valid iff bit_cnt==FRAME_W && rw==1 && addr<NUM_REGS.
//       valid: reg[addr] <= data, wr_addr <= addr, wr_pulse=1 in that clk (regs_o and pulse same cycle).
//       invalid (short/long frame, addr out of range): no register change, frame_err=1.
//       rw==0 with exact length: no change, no error (read frame).
//   - Latency: regs_o updates 1 clk after synchronised nCS rise (~3-4 clk after pin edge).
//   - nCS fall while in COMMIT: accepted next clk (IDLE then SHIFT); no frame lost at clk >= 4x sclk.
//   - Reset mid-frame aborts frame; partially shifted data never reaches regs_o.
//   - Registers are DATA_W-wide; no arithmetic; addr compared unsigned at ADDR_W width.
// CONFIGURATION
//   SPI_READBACK_EN defined:
//     - after 1+ADDR_W bits with rw==0 and addr<NUM_REGS, load reg[addr] into tx shift reg;
//       CIPO drives data MSB first, updating on each sclk fall (master samples on rise);
//       out-of-range addr drives 0; CIPO returns to 0 on nCS rise.
//   SPI_READBACK_EN undefined: CIPO tied 0, no tx logic; read frames ignored as above.
// STRUCTURE
//   - Package spi_reg_pkg: FSM state typedef {IDLE, SHIFT, COMMIT}, FRAME_W function, RW_WRITE=1'b1 constant.
//   - Sub-module spi_sync_edge: 2-flop synchroniser + rise/fall pulse outputs, instanced for sclk, COPI, nCS.
// TESTING (defaults, frame = {rw, addr[6:0], data[7:0]})
//   1. write 0x8080 (addr 0, data 0x80) -> regs_o[7:0]=0x80, wr_pulse once, wr_addr=0, frame_err=0.
//   2. write 0x85FF (addr 5) -> regs_o unchanged, frame_err once, no wr_pulse.
//   3. 15-bit frame, then 17-bit frame of 0x8233.. -> each: frame_err once, regs_o unchanged.
//   4. assert rst_n low after 8 bits of 0x8255 -> all regs 0; next frame 0x8255 -> reg2=0x55.
//   5. back-to-back 0x8111, 0x8322 at min nCS gap -> reg1=0x11, reg3=0x22, two wr_pulses.
//   6. SPI_READBACK_EN: write 0x813C, read 0x0100 -> CIPO bits 8..15 = 0x3C; undefined: CIPO stays 0.

Source files
------------

// File: rtl/spi_reg_peripheral_pkg.sv
// Shared definitions for the SPI register peripheral.
//   state_e   : frame decoder FSM states
//   frame_w() : total frame length {rw, addr, data}
//   RW_WRITE  : value of the rw bit that requests a register write
package spi_reg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  localparam logic RW_WRITE = 1'b1;

  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_reg_peripheral_if.sv
// SPI pin bundle for the register peripheral.
//   sclk, COPI, nCS : driven by the bus master
//   CIPO            : driven by the peripheral
interface spi_reg_peripheral_if;
  logic sclk;
  logic COPI;
  logic nCS;
  logic CIPO;

  modport master (output sclk, output COPI, output nCS, input CIPO);
  modport slave  (input sclk, input COPI, input nCS, output CIPO);
endinterface

// File: rtl/spi_reg_peripheral_sync_edge.sv
// Two-flop synchroniser with edge detection on the synchronised value.
//   clk, rst_n : system clock, asynchronous active-low reset
//   async_i    : asynchronous input pin
//   sync_o     : synchronised level
//   rise_o     : one-clk pulse on a synchronised 0->1 transition
//   fall_o     : one-clk pulse on a synchronised 1->0 transition
// RESET_VAL sets the assumed idle level so no false edge follows reset.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 register peripheral: decodes {rw, addr, data} frames (MSB first)
// and commits valid writes to NUM_REGS x DATA_W registers when nCS deasserts.
//   clk, rst_n : system clock (>= 4x sclk), asynchronous active-low reset
//   spi        : SPI pins (slave modport)
//   regs_o     : flattened registers, reg i at [i*DATA_W +: DATA_W]
//   wr_pulse   : one-clk strobe when a write commits (same cycle as regs_o change)
//   wr_addr    : address of the last committed write
//   frame_err  : one-clk strobe when a frame is rejected
// Build option: define SPI_READBACK_EN to drive register contents on CIPO
// during read frames; otherwise CIPO is tied low.
module spi_reg_peripheral
  import spi_reg_pkg::*;
#(
  parameter int NUM_REGS = 5,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7
) (
  input  logic                         clk,
  input  logic                         rst_n,
  spi_reg_peripheral_if.slave          spi,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o,
  output logic                         wr_pulse,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         frame_err
);

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(FRAME_W + 1);
  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

  logic sclk_s, sclk_rise, sclk_fall;
  logic copi_s, copi_rise, copi_fall;
  logic ncs_s, ncs_rise, ncs_fall;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .async_i(spi.sclk),
    .sync_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall));

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .async_i(spi.COPI),
    .sync_o(copi_s), .rise_o(copi_rise), .fall_o(copi_fall));

  // nCS idles high, so its synchroniser resets high to avoid a phantom select.
  spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .async_i(spi.nCS),
    .sync_o(ncs_s), .rise_o(ncs_rise), .fall_o(ncs_fall));

  logic unused_edges;
  assign unused_edges = ^{sclk_s, sclk_fall, copi_rise, copi_fall, ncs_fall};

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0]  sr_q, sr_d;
  logic                wr_pulse_q, wr_pulse_d;
  logic                frame_err_q, frame_err_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic                commit_en;

  logic [FRAME_W-1:0]  sr_shift;
  logic                frame_rw;
  logic [ADDR_W-1:0]   frame_addr;
  logic [DATA_W-1:0]   frame_data;
  logic                exact_len;
  logic                in_range;

  assign sr_shift   = {sr_q[FRAME_W-2:0], copi_s};
  assign frame_rw   = sr_q[FRAME_W-1];
  assign frame_addr = sr_q[DATA_W +: ADDR_W];
  assign frame_data = sr_q[DATA_W-1:0];
  assign exact_len  = (bit_cnt_q == CNT_W'(FRAME_W));
  assign in_range   = ({1'b0, frame_addr} < NUM_REGS_W);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sr_d        = sr_q;
    wr_pulse_d  = 1'b0;
    frame_err_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    commit_en   = 1'b0;
    case (state_q)
      // Entering on the low level (not only the fall pulse) picks up a
      // select that went low while the previous frame was still committing.
      IDLE: begin
        if (!ncs_s) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          sr_d      = '0;
        end
      end
      SHIFT: begin
        if (ncs_rise) begin
          state_d = COMMIT;
        end else if (sclk_rise) begin
          sr_d = sr_shift;
          if (bit_cnt_q != CNT_MAX) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
        if (exact_len && frame_rw == RW_WRITE && in_range) begin
          commit_en  = 1'b1;
          wr_pulse_d = 1'b1;
          wr_addr_d  = frame_addr;
        end else if (!exact_len || frame_rw == RW_WRITE) begin
          frame_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      wr_pulse_q  <= 1'b0;
      frame_err_q <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      wr_pulse_q  <= wr_pulse_d;
      frame_err_q <= frame_err_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

  assign wr_pulse  = wr_pulse_q;
  assign frame_err = frame_err_q;
  assign wr_addr   = wr_addr_q;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [DATA_W-1:0] reg_q, reg_d;

    always_comb begin
      reg_d = reg_q;
      if (commit_en && frame_addr == ADDR_W'(gi)) begin
        reg_d = frame_data;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) reg_q <= '0;
      else        reg_q <= reg_d;
    end

    assign regs_o[gi*DATA_W +: DATA_W] = reg_q;
  end

`ifdef SPI_READBACK_EN
  logic [DATA_W-1:0] tx_q, tx_d;
  logic              cipo_q, cipo_d;
  logic [DATA_W-1:0] rd_data;

  always_comb begin
    tx_d    = tx_q;
    cipo_d  = cipo_q;
    rd_data = '0;
    // Out-of-range addresses match no register and so read back as zero.
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sr_shift[ADDR_W-1:0] == ADDR_W'(i)) begin
        rd_data = regs_o[i*DATA_W +: DATA_W];
      end
    end
    if (state_q != SHIFT || ncs_rise) begin
      tx_d   = '0;
      cipo_d = 1'b0;
    end else if (sclk_rise && bit_cnt_q == CNT_W'(ADDR_W)) begin
      // This rise completes the {rw, addr} header; a read loads the reply
      // so the first data bit goes out on the following sclk fall.
      if (sr_shift[ADDR_W] != RW_WRITE) begin
        tx_d = rd_data;
      end
    end else if (sclk_fall) begin
      cipo_d = tx_q[DATA_W-1];
      tx_d   = {tx_q[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q   <= '0;
      cipo_q <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      cipo_q <= cipo_d;
    end
  end

  assign spi.CIPO = cipo_q;
`else
  assign spi.CIPO = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Self-checking bench for spi_reg_peripheral (default parameters).
// Directed frames plus randomized frames, compared against a register-array
// model of the frame rules; CIPO expectations follow SPI_READBACK_EN.
module tb_spi_reg_peripheral;

  localparam int NUM_REGS = 5;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 7;
  localparam int HALF     = 60;   // sclk half period in ns (clk period 10 ns)

  logic clk;
  logic rst_n;
  logic [NUM_REGS*DATA_W-1:0] regs_o;
  logic wr_pulse;
  logic [ADDR_W-1:0] wr_addr;
  logic frame_err;

  spi_reg_peripheral_if spi ();

  spi_reg_peripheral #(
    .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .spi(spi), .regs_o(regs_o),
    .wr_pulse(wr_pulse), .wr_addr(wr_addr), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  int wr_cnt = 0;
  int err_cnt = 0;
  logic [DATA_W-1:0] model [NUM_REGS];
  int txn = 0;

`ifdef SPI_READBACK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  always @(negedge clk) begin
    if (wr_pulse === 1'b1) wr_cnt++;
    if (frame_err === 1'b1) err_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_REGS*DATA_W-1:0] model_flat();
    logic [NUM_REGS*DATA_W-1:0] f;
    f = '0;
    for (int i = 0; i < NUM_REGS; i++) f[i*DATA_W +: DATA_W] = model[i];
    return f;
  endfunction

  // Shift n bits MSB first in mode 0, capturing CIPO at every sclk rise.
  task automatic shift_bits(input logic [31:0] bits, input int n, output logic [31:0] rx);
    rx = '0;
    for (int k = n - 1; k >= 0; k--) begin
      spi.COPI = bits[k];
      #(HALF);
      rx = {rx[30:0], spi.CIPO};
      spi.sclk = 1'b1;
      #(HALF);
      spi.sclk = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [31:0] bits, input int n, input int gap, output logic [31:0] rx);
    spi.nCS = 1'b0;
    #(HALF);
    shift_bits(bits, n, rx);
    #(HALF);
    spi.nCS = 1'b1;
    spi.COPI = 1'b0;
    #(gap);
  endtask

  // Send one frame built from a 16-bit word: len 15 drops the last bit,
  // len 17 appends one extra bit. Checks the outcome against the model.
  task automatic run_frame(input logic [15:0] word, input int len, output logic [31:0] rx);
    logic [31:0] bits;
    logic [31:0] exp_rx;
    logic rw;
    int addr;
    logic [7:0] data;
    int exp_wr, exp_err, w0, e0;
    bit rd_ok;
    rw   = word[15];
    addr = int'(word[14:8]);
    data = word[7:0];
    if (len == 15)      bits = {17'd0, word[15:1]};
    else if (len == 17) bits = {15'd0, word, 1'($urandom_range(0, 1))};
    else                bits = {16'd0, word};
    // Reply bits appear on rises 8..15 for an in-range read header.
    rd_ok  = RB_EN && !rw && addr < NUM_REGS;
    exp_rx = '0;
    for (int k = 0; k < len; k++) begin
      exp_rx = {exp_rx[30:0], (rd_ok && k >= 8 && k <= 15) ? model[addr][15 - k] : 1'b0};
    end
    exp_wr = 0;
    exp_err = 0;
    if (len == 16 && rw && addr < NUM_REGS) begin
      exp_wr = 1;
      model[addr] = data;
    end else if (len != 16 || rw) begin
      exp_err = 1;
    end
    @(negedge clk);
    w0 = wr_cnt;
    e0 = err_cnt;
    spi_frame(bits, len, 30, rx);
    repeat (12) @(negedge clk);
    txn++;
    $display("[TB] txn %0d word=0x%04h len=%0d regs=0x%010h wr=%0d err=%0d rx=0x%0h",
             txn, word, len, regs_o, wr_cnt - w0, err_cnt - e0, rx);
    check("wr_pulse_count", 64'(wr_cnt - w0), 64'(exp_wr));
    check("frame_err_count", 64'(err_cnt - e0), 64'(exp_err));
    check("regs_o", 64'(regs_o), 64'(model_flat()));
    check("cipo_rx", 64'(rx), 64'(exp_rx));
    check("cipo_idle", 64'(spi.CIPO), 64'd0);
    if (exp_wr == 1) check("wr_addr", 64'(wr_addr), 64'(addr));
  endtask

  initial begin
    logic [31:0] rx;
    logic [15:0] w;
    int len, r, w0, e0, w1;
    spi.sclk = 1'b0;
    spi.COPI = 1'b0;
    spi.nCS  = 1'b1;
    rst_n    = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    check("reset_regs", 64'(regs_o), 64'd0);
    check("reset_wr_addr", 64'(wr_addr), 64'd0);
    check("reset_wr_pulse", 64'(wr_pulse), 64'd0);
    check("reset_frame_err", 64'(frame_err), 64'd0);
    check("reset_cipo", 64'(spi.CIPO), 64'd0);

    // Valid write to reg 0, then out-of-range write.
    run_frame(16'h8080, 16, rx);
    check("reg0_0x80", 64'(regs_o[7:0]), 64'h80);
    run_frame(16'h85FF, 16, rx);
    // Short and long frames.
    run_frame(16'h8233, 15, rx);
    run_frame(16'h8233, 17, rx);

    // Randomized frames.
    for (int t = 0; t < 24; t++) begin
      w = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), 8'($urandom)};
      r = $urandom_range(0, 9);
      len = (r == 0) ? 15 : (r == 1) ? 17 : 16;
      run_frame(w, len, rx);
    end

    // Reset in the middle of a frame: nothing partial may land.
    @(negedge clk);
    w0 = wr_cnt;
    e0 = err_cnt;
    spi.nCS = 1'b0;
    #(HALF);
    shift_bits(32'h82, 8, rx);
    rst_n = 1'b0;
    spi.nCS = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    txn++;
    $display("[TB] txn %0d reset mid-frame regs=0x%010h", txn, regs_o);
    check("abort_regs", 64'(regs_o), 64'd0);
    check("abort_wr_addr", 64'(wr_addr), 64'd0);
    check("abort_no_pulse", 64'(wr_cnt - w0), 64'd0);
    run_frame(16'h8255, 16, rx);
    check("reg2_0x55", 64'(regs_o[23:16]), 64'h55);

    // Back-to-back writes with a 3-clk nCS gap.
    @(negedge clk);
    w1 = wr_cnt;
    spi_frame(32'h8111, 16, 30, rx);
    spi_frame(32'h8322, 16, 0, rx);
    model[1] = 8'h11;
    model[3] = 8'h22;
    repeat (12) @(negedge clk);
    txn++;
    $display("[TB] txn %0d back-to-back regs=0x%010h wr=%0d", txn, regs_o, wr_cnt - w1);
    check("b2b_pulses", 64'(wr_cnt - w1), 64'd2);
    check("b2b_regs", 64'(regs_o), 64'(model_flat()));
    check("b2b_wr_addr", 64'(wr_addr), 64'd3);

    // Readback of a freshly written register.
    run_frame(16'h813C, 16, rx);
    run_frame(16'h0100, 16, rx);
    check("readback_rx", 64'(rx[15:0]), RB_EN ? 64'h003C : 64'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
